// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader and the Program_Control benches:
// FSM state encodings and default memory geometry.
package instruction_loader_pkg;

    localparam int DEPTH_DEF  = 128;
    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CKSUM  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    // States in which the loader takes a word from the input stream.
    function automatic logic accepts_data(input state_t s);
        return (s == ST_LOAD) || (s == ST_CKSUM);
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Stream-in / memory-write-out bundle of the instruction loader.
// master = stream source and memory side; slave = the loader.
interface instruction_loader_if
    import instruction_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              start;
    logic [ADDR_W:0]   load_len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] writeAddress;
    logic [DATA_W-1:0] writeInstruction;
    logic              writeEnable;
    logic              suspendEnable;
    logic              done;
    logic              error;

    modport master (
        output start, load_len, in_valid, in_data,
        input  in_ready, writeAddress, writeInstruction, writeEnable,
               suspendEnable, done, error
    );

    modport slave (
        input  start, load_len, in_valid, in_data,
        output in_ready, writeAddress, writeInstruction, writeEnable,
               suspendEnable, done, error
    );
endinterface

// File: rtl/instruction_loader_checksum.sv
// loader_checksum: wrapping sum of accepted data words, compared against the
// trailing checksum word. Only instantiated with INSTRUCTION_LOADER_CHECKSUM_EN.
module loader_checksum #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              srst,
    input  logic              clear,
    input  logic              add,
    input  logic [DATA_W-1:0] add_data,
    input  logic [DATA_W-1:0] cmp_data,
    output logic              match
);
    logic [DATA_W-1:0] sum_r;

    // Accumulator: cleared at load start, adds each accepted data word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_r <= {DATA_W{1'b0}};
        end else if (srst || clear) begin
            sum_r <= {DATA_W{1'b0}};
        end else if (add) begin
            sum_r <= sum_r + add_data;
        end else begin
            sum_r <= sum_r;
        end
    end

    // Compare the running sum with the word currently presented.
    always_comb begin
        match = (sum_r == cmp_data);
    end
endmodule

// File: rtl/instruction_loader.sv
// Instruction memory fill engine: streams words into memory while holding the PC
// suspended. Optional trailing checksum when INSTRUCTION_LOADER_CHECKSUM_EN is defined.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic srst,
    instruction_loader_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   cnt_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic              suspend_r;
    logic              done_r;
    logic              error_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              last_s;
    logic [ADDR_W:0]   len_s;

    assign in_ready_s = accepts_data(state_r);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign last_s     = (cnt_r == (len_r - ONE_L));
    assign len_s      = (bus.load_len == {(ADDR_W + 1){1'b0}}) ? DEPTH_L : bus.load_len;

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic start_ok_s;
    logic cksum_add_s;
    logic cksum_match_s;

    assign start_ok_s  = bus.start && ((state_r == ST_IDLE) || (state_r == ST_RUN) ||
                                       (state_r == ST_ERROR));
    assign cksum_add_s = accept_s && (state_r == ST_LOAD);

    loader_checksum #(.DATA_W(DATA_W)) u_checksum (
        .clk      (clk),
        .reset    (reset),
        .srst     (srst),
        .clear    (start_ok_s),
        .add      (cksum_add_s),
        .add_data (bus.in_data),
        .cmp_data (bus.in_data),
        .match    (cksum_match_s)
    );
`endif

    // Loader FSM with word counter and registered memory-write / status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            len_r     <= {(ADDR_W + 1){1'b0}};
            cnt_r     <= {(ADDR_W + 1){1'b0}};
            we_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            data_r    <= {DATA_W{1'b0}};
            suspend_r <= 1'b1;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else if (srst) begin
            state_r   <= ST_IDLE;
            len_r     <= {(ADDR_W + 1){1'b0}};
            cnt_r     <= {(ADDR_W + 1){1'b0}};
            we_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            data_r    <= {DATA_W{1'b0}};
            suspend_r <= 1'b1;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            we_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    if (bus.start) begin
                        state_r   <= ST_LOAD;
                        len_r     <= len_s;
                        cnt_r     <= {(ADDR_W + 1){1'b0}};
                        suspend_r <= 1'b1;
                        done_r    <= 1'b0;
                        error_r   <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        we_r   <= 1'b1;
                        addr_r <= cnt_r[ADDR_W-1:0];
                        data_r <= bus.in_data;
                        cnt_r  <= cnt_r + ONE_L;
                        if (last_s) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                            state_r <= ST_CKSUM;
`else
                            state_r <= ST_SETTLE;
`endif
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                // The checksum word is consumed here and never written to memory.
                ST_CKSUM: begin
                    if (accept_s) begin
                        if (cksum_match_s) begin
                            state_r <= ST_SETTLE;
                        end else begin
                            state_r <= ST_ERROR;
                            error_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_CKSUM;
                    end
                end
`endif
                ST_SETTLE: begin
                    state_r   <= ST_RUN;
                    suspend_r <= 1'b0;
                    done_r    <= 1'b1;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    suspend_r <= 1'b1;
                    done_r    <= 1'b0;
                    error_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready         = in_ready_s;
    assign bus.writeEnable      = we_r;
    assign bus.writeAddress     = addr_r;
    assign bus.writeInstruction = data_r;
    assign bus.suspendEnable    = suspend_r;
    assign bus.done             = done_r;
    assign bus.error            = error_r;
endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares them against the write port.
module tb_instruction_loader;
    logic clk;
    logic reset;
    logic srst;

    instruction_loader_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    instruction_loader #(.DEPTH(128), .ADDR_W(7), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .srst  (srst),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   wr_count = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.writeEnable === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual_addr=0x%0h actual_data=0x%0h required=none",
                         bus.writeAddress, bus.writeInstruction);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("write_addr", {57'd0, bus.writeAddress}, {57'd0, e.addr});
                chk("write_data", {32'd0, bus.writeInstruction}, {32'd0, e.data});
            end
        end
    end

    // Called just after a rising edge; leaves the bench just after a rising edge.
    task automatic do_start(input logic [7:0] len);
        bus.start    = 1'b1;
        bus.load_len = len;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("ready_after_start", {63'd0, bus.in_ready}, 64'd1);
        chk("suspend_after_start", {63'd0, bus.suspendEnable}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Offer one word until accepted; push the expected write if it goes to memory.
    task automatic send_word(input logic [31:0] w, input logic [6:0] k, input bit to_mem);
        bit seen = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1");
        end else if (to_mem) begin
            exp_q.push_back('{addr: k, data: w});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic gap_cycle(input logic start_pulse);
        bus.in_data = 32'hDEADBEEF;
        bus.start   = start_pulse;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Checks the SETTLE cycle and then RUN, starting right after the last accept.
    task automatic check_finish(input string tag);
        @(negedge clk);
        chk({tag, "_settle_done"}, {63'd0, bus.done}, 64'd0);
        chk({tag, "_settle_susp"}, {63'd0, bus.suspendEnable}, 64'd1);
        @(negedge clk);
        chk({tag, "_run_done"}, {63'd0, bus.done}, 64'd1);
        chk({tag, "_run_susp"}, {63'd0, bus.suspendEnable}, 64'd0);
        chk({tag, "_run_we"}, {63'd0, bus.writeEnable}, 64'd0);
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base;
        reset        = 1'b0;
        srst         = 1'b0;
        bus.start    = 1'b0;
        bus.load_len = 8'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        #1;
        chk("rst_we", {63'd0, bus.writeEnable}, 64'd0);
        chk("rst_addr", {57'd0, bus.writeAddress}, 64'd0);
        chk("rst_data", {32'd0, bus.writeInstruction}, 64'd0);
        chk("rst_err", {63'd0, bus.error}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Idle with no start.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("idle_susp", {63'd0, bus.suspendEnable}, 64'd1);
            chk("idle_we", {63'd0, bus.writeEnable}, 64'd0);
            chk("idle_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("idle_done", {63'd0, bus.done}, 64'd0);
        end
        @(posedge clk);
        #1;

        // Full-depth load with in_valid held high.
        base = wr_count;
        do_start(8'd0);
        for (int i = 0; i < 128; i++) begin
            send_word(32'h5ADFACED - 32'(i), 7'(i), 1'b1);
        end
        check_finish("full");
        chk("full_wr_count", 64'(wr_count - base), 64'd128);

        // Three words with gaps; gap data must never reach memory.
        base = wr_count;
        do_start(8'd3);
        send_word(32'h11111111, 7'd0, 1'b1);
        gap_cycle(1'b0);
        send_word(32'h22222222, 7'd1, 1'b1);
        gap_cycle(1'b0);
        send_word(32'h33333333, 7'd2, 1'b1);
        check_finish("gap");
        chk("gap_wr_count", 64'(wr_count - base), 64'd3);

        // Reload from RUN with a start pulse during LOAD that must be ignored.
        base = wr_count;
        do_start(8'd4);
        send_word(32'hA0000000, 7'd0, 1'b1);
        send_word(32'hA0000001, 7'd1, 1'b1);
        gap_cycle(1'b1);
        send_word(32'hA0000002, 7'd2, 1'b1);
        send_word(32'hA0000003, 7'd3, 1'b1);
        check_finish("reload");
        chk("reload_wr_count", 64'(wr_count - base), 64'd4);

        // Asynchronous reset after 10 accepts, then a fresh load from address 0.
        do_start(8'd0);
        for (int i = 0; i < 10; i++) begin
            send_word(32'hC0DE0000 + 32'(i), 7'(i), 1'b1);
        end
        chk("pre_reset_we", {63'd0, bus.writeEnable}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_we", {63'd0, bus.writeEnable}, 64'd0);
        chk("mid_rst_addr", {57'd0, bus.writeAddress}, 64'd0);
        chk("mid_rst_data", {32'd0, bus.writeInstruction}, 64'd0);
        chk("mid_rst_susp", {63'd0, bus.suspendEnable}, 64'd1);
        chk("mid_rst_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("mid_rst_done", {63'd0, bus.done}, 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk);
        #1;
        base = wr_count;
        do_start(8'd3);
        send_word(32'hBEEF0000, 7'd0, 1'b1);
        send_word(32'hBEEF0001, 7'd1, 1'b1);
        send_word(32'hBEEF0002, 7'd2, 1'b1);
        check_finish("after_rst");
        chk("after_rst_wr_count", 64'(wr_count - base), 64'd3);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        base = wr_count;
        do_start(8'd2);
        send_word(32'h00000001, 7'd0, 1'b1);
        send_word(32'h00000002, 7'd1, 1'b1);
        send_word(32'h00000003, 7'd0, 1'b0);
        check_finish("cksum_ok");
        chk("cksum_ok_err", {63'd0, bus.error}, 64'd0);

        do_start(8'd2);
        send_word(32'h00000001, 7'd0, 1'b1);
        send_word(32'h00000002, 7'd1, 1'b1);
        send_word(32'h00000004, 7'd0, 1'b0);
        @(negedge clk);
        chk("cksum_bad_err", {63'd0, bus.error}, 64'd1);
        chk("cksum_bad_susp", {63'd0, bus.suspendEnable}, 64'd1);
        chk("cksum_bad_done", {63'd0, bus.done}, 64'd0);
        chk("cksum_wr_count", 64'(wr_count - base), 64'd4);
        @(posedge clk);
        #1;
`else
        chk("err_tied_low", {63'd0, bus.error}, 64'd0);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_loader.md
# instruction_loader

Upstream fill engine for `Program_Control`: accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into instruction memory through the `writeAddress`/`writeInstruction`/`writeEnable` port. While loading it holds `suspendEnable` high so the PC stays frozen. After the last write it releases `suspendEnable` so execution starts from address 0. The block replaces the hand-sequenced memory fill currently done by benches and boot logic.

## Interface
- `DEPTH`, 128, number of instruction-memory words; power of two.
- `ADDR_W`, 7, log2(DEPTH); width of `writeAddress`.
- `DATA_W`, 32, instruction width.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-low.
- `start` input 1: request a (re)load; sampled on the rising edge.
- `load_len` input ADDR_W+1: word count captured when `start` is accepted; 0 means DEPTH.
- `in_valid` input 1: `in_data` holds a word.
- `in_data` input DATA_W: instruction word, or the checksum word (see Configuration).
- `in_ready` output 1: block accepts `in_data` on this edge.
- `writeAddress` output ADDR_W: memory write address.
- `writeInstruction` output DATA_W: memory write data.
- `writeEnable` output 1: memory write strobe.
- `suspendEnable` output 1: freezes `Program_Control`.
- `done` output 1: load completed successfully; PC running.
- `error` output 1: checksum mismatch; always 0 when the checksum feature is compiled out.

## Operation
- States:
  - IDLE: after reset, waiting for `start`.
  - LOAD: accepting data words.
  - CKSUM: accepting the checksum word; present only with the macro.
  - SETTLE: one-cycle gap after the last write.
  - RUN: load complete, PC released.
  - ERROR: checksum mismatch; present only with the macro.
- Transitions:
  - IDLE, RUN or ERROR with `start`=1 → LOAD. On entry: capture `load_len` (0 → DEPTH), clear word count and checksum accumulator, set `suspendEnable`, clear `done` and `error`.
  - LOAD, `start` is ignored.
  - LOAD, the accept of word N-1 (N = captured length) → SETTLE, or → CKSUM with the macro.
  - CKSUM, on accept: compare → SETTLE if equal, ERROR if not.
  - SETTLE → RUN unconditionally.
- Handshake:
  - A word is accepted on an edge where `in_valid && in_ready`.
  - `in_ready` = (state==LOAD || state==CKSUM); it is combinational from state only and never depends on `in_valid`.
  - `in_data` seen while `in_ready`=0 is ignored and never written.
- Write generation, all registered:
  - For an accept of word k at edge t: during cycle t+1, `writeEnable`=1, `writeAddress`=k[ADDR_W-1:0], `writeInstruction`=the accepted word.
  - Memory captures the word at edge t+1.
  - With no accept at edge t, `writeEnable`=0 in cycle t+1, and address/data hold their last value.
- Address arithmetic: k counts from 0; the counter is ADDR_W+1 bits wide so N=DEPTH terminates without wrapping to 0.
- `suspendEnable`=0 only in RUN; it is 1 in every other state, including ERROR.
- `done`=1 only in RUN.

## Timing
- Reset values: `writeEnable`=0, `writeAddress`=0, `writeInstruction`=0, `suspendEnable`=1, `in_ready`=0, `done`=0, `error`=0; state IDLE.
- `start` at edge t → `in_ready`=1 in cycle t+1.
- Back-to-back accepts give one write per cycle: full throughput, latency 1.
- Last data accept at edge t (no checksum):
  - cycle t+1: final write, in SETTLE;
  - cycle t+2: `writeEnable`=0, RUN, `suspendEnable`=0, `done`=1.
- Reset asserted mid-load: outputs return to reset values immediately (asynchronous). Partially written memory is left as is. A new `start` is required.
- `start` while in RUN: `suspendEnable` rises in the next cycle. The PC is therefore frozen before any overwrite reaches memory.

## Configuration
- Macro `INSTRUCTION_LOADER_CHECKSUM_EN`.
- Defined:
  - after N data words, one extra word is accepted in CKSUM and never written to memory;
  - it is compared with the 32-bit wrapping sum of the N data words;
  - equal → SETTLE → RUN;
  - unequal → ERROR, with `error`=1 and `suspendEnable` held at 1.
- Undefined: CKSUM and ERROR states, the accumulator and the compare logic are absent; `error` is tied to 0.

## Structure
- Shared package / header `instruction_loader_pkg`: state encodings (IDLE, LOAD, CKSUM, SETTLE, RUN, ERROR) and default DEPTH/ADDR_W/DATA_W constants, shared with the `Program_Control` benches.
- One sub-module, `loader_checksum`: accumulator with clear, add-on-accept and compare.
- Everything else is a single FSM plus counter in `instruction_loader`.

## Test plan
- Reset, no `start` → `suspendEnable`=1, `writeEnable`=0, `in_ready`=0, `done`=0 indefinitely.
- `start`, `load_len`=0, 128 words from 0x5ADFACED decrementing with `in_valid` held high → 128 consecutive `writeEnable` cycles, addresses 0x00..0x7F. Address 0x7F holds 0x5ADFAC6E. `done`=1 and `suspendEnable`=0 two cycles after the last accept. `Program_Control` then fetches 0x5ADFACED first.
- `load_len`=3, `in_valid` toggled 1,0,1,0,1 → exactly three writes to addresses 0,1,2. No write occurs in the gap cycles. RUN follows.
- Reset pulled low after 10 accepts → all outputs return to reset values within the same cycle. A new `start` rewrites from address 0.
- With macro, `load_len`=2, words 0x1 and 0x2, then checksum 0x3 → RUN with `error`=0. Repeating with checksum 0x4 → ERROR, `error`=1, `suspendEnable`=1, `done`=0, and only two memory writes issued.
- `start` asserted while in RUN → `suspendEnable`=1 in the next cycle and the reload completes normally. `start` pulses during LOAD are ignored.
